// File: rtl/hist_pkg.sv
// Shared histogram constants, frame-reducer state encoding and result payload.
package hist_pkg;

  localparam int unsigned NUM_BINS = 64;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned TOTAL_W  = 14;
  localparam int unsigned OCC_W    = IDX_W + 1;
  localparam int unsigned BEAT_W   = IDX_W + 1;
  localparam int unsigned FCNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0]   peak_bin;
    logic [DATA_W-1:0]  peak_count;
    logic [TOTAL_W-1:0] total_count;
    logic [OCC_W-1:0]   occupied_bins;
  } hist_stats_t;

endpackage

// File: rtl/hist_peak_cmp.sv
// Running-peak select: a new beat replaces the peak only when strictly greater,
// so ties keep the lowest bin index.
module hist_peak_cmp
  import hist_pkg::*;
(
  input  logic [DATA_W-1:0] run_peak_i,
  input  logic [IDX_W-1:0]  run_bin_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] nxt_peak_c_o,
  output logic [IDX_W-1:0]  nxt_bin_c_o
);

  always_comb begin
    nxt_peak_c_o = run_peak_i;
    nxt_bin_c_o  = run_bin_i;
    if (data_i > run_peak_i) begin
      nxt_peak_c_o = data_i;
      nxt_bin_c_o  = idx_i;
    end
  end

endmodule

// File: rtl/histogram_stats.sv
// Reduces each 64-bin histogram dump to peak bin/count, total and occupancy,
// publishing with a one-cycle strobe and flagging short or overlong frames.
module histogram_stats
  import hist_pkg::*;
(
  input  logic               clk,
  input  logic               bin_reset,
  input  logic               clear,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               last_in,
  output logic [IDX_W-1:0]   peak_bin,
  output logic [DATA_W-1:0]  peak_count,
  output logic [TOTAL_W-1:0] total_count,
  output logic [OCC_W-1:0]   occupied_bins,
  output logic               stats_valid,
  output logic               frame_error,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(NUM_BINS - 1);
  localparam logic [BEAT_W-1:0] OVER_IDX = BEAT_W'(NUM_BINS);

  state_e              state_q;
  logic [BEAT_W-1:0]   idx_q;
  logic [DATA_W-1:0]   run_peak_q;
  logic [IDX_W-1:0]    run_bin_q;
  logic [TOTAL_W-1:0]  run_total_q;
  logic [OCC_W-1:0]    run_occ_q;
  hist_stats_t         res_q;
  logic                stats_valid_q;
  logic                frame_error_q;
  logic [FCNT_W-1:0]   frame_cnt_q;

  logic [DATA_W-1:0]   peak_d;
  logic [IDX_W-1:0]    bin_d;
  logic [TOTAL_W-1:0]  total_d;
  logic [OCC_W-1:0]    occ_d;

  hist_peak_cmp u_peak_cmp (
    .run_peak_i   (run_peak_q),
    .run_bin_i    (run_bin_q),
    .data_i       (data_in),
    .idx_i        (idx_q[IDX_W-1:0]),
    .nxt_peak_c_o (peak_d),
    .nxt_bin_c_o  (bin_d)
  );

  // Running sums including the current beat.
  always_comb begin
    total_d = run_total_q + TOTAL_W'(data_in);
    occ_d   = run_occ_q + OCC_W'(data_in != '0);
  end

  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      run_peak_q    <= '0;
      run_bin_q     <= '0;
      run_total_q   <= '0;
      run_occ_q     <= '0;
      res_q         <= '0;
      stats_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (clear) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      run_peak_q    <= '0;
      run_bin_q     <= '0;
      run_total_q   <= '0;
      run_occ_q     <= '0;
      res_q         <= '0;
      stats_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      stats_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid_in) begin
            run_peak_q  <= data_in;
            run_bin_q   <= '0;
            run_total_q <= TOTAL_W'(data_in);
            run_occ_q   <= OCC_W'(data_in != '0);
            idx_q       <= BEAT_W'(1);
            // A one-beat frame can never be complete.
            if (last_in) begin
              frame_error_q <= 1'b1;
              state_q       <= IDLE;
            end else begin
              state_q       <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (valid_in) begin
            run_peak_q  <= peak_d;
            run_bin_q   <= bin_d;
            run_total_q <= total_d;
            run_occ_q   <= occ_d;
            idx_q       <= idx_q + BEAT_W'(1);
            if (last_in) begin
              state_q <= IDLE;
              if (idx_q == LAST_IDX) begin
                res_q.peak_bin      <= bin_d;
                res_q.peak_count    <= peak_d;
                res_q.total_count   <= total_d;
                res_q.occupied_bins <= occ_d;
                stats_valid_q       <= 1'b1;
                frame_error_q       <= 1'b0;
                frame_cnt_q         <= frame_cnt_q + FCNT_W'(1);
              end else begin
                frame_error_q <= 1'b1;
              end
            end else if (idx_q == OVER_IDX) begin
              frame_error_q <= 1'b1;
              state_q       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (valid_in && last_in) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign peak_bin      = res_q.peak_bin;
  assign peak_count    = res_q.peak_count;
  assign total_count   = res_q.total_count;
  assign occupied_bins = res_q.occupied_bins;
  assign stats_valid   = stats_valid_q;
  assign frame_error   = frame_error_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_histogram_stats.sv
// Self-checking bench for histogram_stats: queue-based frame model compared
// every cycle, plus literal expectations after each directed frame.
module tb_histogram_stats;

  logic       clk = 1'b0;
  logic       bin_reset;
  logic       clear;
  logic       valid_in;
  logic [7:0] data_in;
  logic       last_in;
  logic [5:0] peak_bin;
  logic [7:0] peak_count;
  logic [13:0] total_count;
  logic [6:0] occupied_bins;
  logic       stats_valid;
  logic       frame_error;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int fr[64];

  // model expectations
  int exp_bin, exp_peak, exp_total, exp_occ, exp_sv, exp_err, exp_cnt;
  int beats[$];
  bit draining;

  histogram_stats dut (
    .clk           (clk),
    .bin_reset     (bin_reset),
    .clear         (clear),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .last_in       (last_in),
    .peak_bin      (peak_bin),
    .peak_count    (peak_count),
    .total_count   (total_count),
    .occupied_bins (occupied_bins),
    .stats_valid   (stats_valid),
    .frame_error   (frame_error),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_zero();
    exp_bin = 0; exp_peak = 0; exp_total = 0; exp_occ = 0;
    exp_sv = 0; exp_err = 0; exp_cnt = 0;
    beats.delete();
    draining = 1'b0;
  endtask

  // Frame-level model: collect beats, reduce the whole frame when it ends.
  always @(posedge clk or posedge bin_reset) begin
    if (bin_reset || clear) begin
      model_zero();
    end else begin
      exp_sv = 0;
      if (valid_in) begin
        if (draining) begin
          if (last_in) draining = 1'b0;
        end else begin
          beats.push_back(int'(data_in));
          if (last_in) begin
            if (beats.size() == 64) begin
              int pk, bn, tot, occ;
              pk = beats[0]; bn = 0; tot = 0; occ = 0;
              foreach (beats[j]) begin
                if (beats[j] > pk) begin pk = beats[j]; bn = j; end
                tot += beats[j];
                if (beats[j] != 0) occ++;
              end
              exp_bin = bn; exp_peak = pk; exp_total = tot; exp_occ = occ;
              exp_sv = 1; exp_err = 0; exp_cnt = (exp_cnt + 1) % 256;
            end else begin
              exp_err = 1;
            end
            beats.delete();
          end else if (beats.size() > 64) begin
            exp_err = 1;
            draining = 1'b1;
            beats.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_peak_bin", int'(peak_bin), exp_bin);
      chk("m_peak_count", int'(peak_count), exp_peak);
      chk("m_total", int'(total_count), exp_total);
      chk("m_occupied", int'(occupied_bins), exp_occ);
      chk("m_stats_valid", int'(stats_valid), exp_sv);
      chk("m_frame_error", int'(frame_error), exp_err);
      chk("m_frame_cnt", int'(frame_cnt), exp_cnt);
    end
  end

  task automatic beat(input int d, input bit l);
    valid_in = 1'b1;
    data_in  = 8'(d);
    last_in  = l;
    @(posedge clk); #2;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #2;
  endtask

  // nb beats from fr[], optional last on the final beat, optional idle gaps
  task automatic send_frame(input int nb, input bit with_last, input int gap_every);
    for (int i = 0; i < nb; i++) begin
      beat(fr[i % 64], with_last && (i == nb - 1));
      if (gap_every > 0 && (i % gap_every) == gap_every - 1 && i != nb - 1)
        idle_cycle();
    end
  endtask

  task automatic lit(input int b, input int p, input int t, input int o,
                     input int sv, input int er, input int c);
    chk("l_peak_bin", int'(peak_bin), b);
    chk("l_peak_count", int'(peak_count), p);
    chk("l_total", int'(total_count), t);
    chk("l_occupied", int'(occupied_bins), o);
    chk("l_stats_valid", int'(stats_valid), sv);
    chk("l_frame_error", int'(frame_error), er);
    chk("l_frame_cnt", int'(frame_cnt), c);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) fr[i] = i;
  endtask

  task automatic fill_tie();
    for (int i = 0; i < 64; i++) fr[i] = 1;
    fr[5] = 255;
    fr[40] = 255;
  endtask

  initial begin
    bin_reset = 1'b1; clear = 1'b0; valid_in = 1'b0; data_in = '0; last_in = 1'b0;
    repeat (2) @(posedge clk);
    #2 bin_reset = 1'b0;
    lit(0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    idle_cycle();

    // ramp frame
    fill_ramp();
    send_frame(64, 1'b1, 0);
    lit(63, 63, 2016, 63, 1, 0, 1);
    idle_cycle();
    chk("l_sv_one_cycle", int'(stats_valid), 0);

    // ties keep lowest index
    fill_tie();
    send_frame(64, 1'b1, 0);
    lit(5, 255, 572, 64, 1, 0, 2);
    idle_cycle();

    // same frame with three gaps
    send_frame(64, 1'b1, 20);
    lit(5, 255, 572, 64, 1, 0, 3);
    idle_cycle();

    // short frame: last on beat 20
    fill_ramp();
    send_frame(21, 1'b1, 0);
    lit(5, 255, 572, 64, 0, 1, 3);
    idle_cycle();
    send_frame(64, 1'b1, 0);
    lit(63, 63, 2016, 63, 1, 0, 4);
    idle_cycle();

    // long frame: 70 beats, error at beat 64
    send_frame(65, 1'b0, 0);
    chk("l_long_err_at_64", int'(frame_error), 1);
    for (int i = 0; i < 4; i++) beat(9, 1'b0);
    beat(9, 1'b1);
    lit(63, 63, 2016, 63, 0, 1, 4);

    // back-to-back recovery frames
    fill_tie();
    send_frame(64, 1'b1, 0);
    lit(5, 255, 572, 64, 1, 0, 5);
    for (int i = 0; i < 64; i++) fr[i] = (i * 7) % 256;
    send_frame(64, 1'b1, 0);
    chk("l_b2b_cnt", int'(frame_cnt), 6);
    chk("l_b2b_sv", int'(stats_valid), 1);
    idle_cycle();

    // mid-frame clear, simultaneous beat dropped
    send_frame(30, 1'b0, 0);
    clear = 1'b1; valid_in = 1'b1; data_in = 8'd200;
    @(posedge clk); #2;
    clear = 1'b0; valid_in = 1'b0;
    lit(0, 0, 0, 0, 0, 0, 0);
    fill_ramp();
    send_frame(64, 1'b1, 0);
    lit(63, 63, 2016, 63, 1, 0, 1);

    // mid-frame async reset
    send_frame(30, 1'b0, 0);
    bin_reset = 1'b1;
    #1;
    lit(0, 0, 0, 0, 0, 0, 0);
    idle_cycle();
    bin_reset = 1'b0;
    idle_cycle();
    lit(0, 0, 0, 0, 0, 0, 0);

    // 256 good frames wrap frame_cnt
    for (int f = 0; f < 255; f++) send_frame(64, 1'b1, 0);
    chk("l_cnt_255", int'(frame_cnt), 255);
    send_frame(64, 1'b1, 0);
    lit(63, 63, 2016, 63, 1, 0, 0);
    idle_cycle();
    idle_cycle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/histogram_stats.md
# histogram_stats

Downstream consumer of the histogram dump stream. Receives the 64-bin burst the histogrammer emits when a bin saturates, and reduces each frame to peak bin, peak count, total count and occupied-bin count. Results are published with a one-cycle strobe and held until the next valid frame. It also flags malformed frames, so firmware reads a compact summary instead of 64 raw counts.

## Interface
Parameters:
- NUM_BINS, 64, bins per frame
- DATA_W, 8, width of one bin count
- IDX_W, 6, log2(NUM_BINS)
- TOTAL_W, 14, total-count width (64×255 = 16320 fits)

Ports:
- clk  in  1  clock, rising edge
- bin_reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort; returns the block to its post-reset state
- valid_in  in  1  bin beat valid
- data_in  in  DATA_W  bin count, bin 0 first
- last_in  in  1  marks bin NUM_BINS-1; valid only with valid_in
- peak_bin  out  IDX_W  index of the largest bin
- peak_count  out  DATA_W  value of the largest bin
- total_count  out  TOTAL_W  sum of all bins
- occupied_bins  out  IDX_W+1  number of nonzero bins (0..64)
- stats_valid  out  1  one-cycle strobe: new results published
- frame_error  out  1  last frame was malformed; held until the next good frame
- frame_cnt  out  8  good frames published; wraps 255→0

## Operation
- States:
  - IDLE: waiting for a first beat.
  - ACCUM: frame in progress.
  - DRAIN: overlong frame; discard beats until last_in.
- Beat counter idx (IDX_W+1 bits) counts accepted beats. A beat is accepted only when valid_in=1.
- Gaps (valid_in=0) inside a frame are legal. The frame stays in ACCUM and no state changes.
- IDLE + valid_in: start a frame.
  - Initialise running values from this beat: run_peak=data_in, run_bin=0, run_total=data_in, run_occ=(data_in!=0), idx=1.
  - Go to ACCUM, or take the end-of-frame check below if last_in=1.
- ACCUM + valid_in:
  - If data_in > run_peak (strictly greater), set run_peak=data_in and run_bin=idx. Ties keep the lowest index.
  - Add data_in to run_total, zero-extended to TOTAL_W.
  - Increment run_occ if data_in != 0.
  - Increment idx.
- End-of-frame check on the beat carrying last_in:
  - That beat is bin 63 (idx==63 before increment): good frame.
    - Register the final values, including this beat, into the outputs.
    - Pulse stats_valid, clear frame_error, increment frame_cnt.
    - Go to IDLE.
  - Any other idx: short frame.
    - Set frame_error; leave outputs unchanged; no stats_valid.
    - Go to IDLE.
- Beat 64 arrives without last_in (long frame): set frame_error and go to DRAIN.
- DRAIN + valid_in + last_in: go to IDLE. No stats_valid, outputs unchanged.
- clear:
  - Forces IDLE and zeroes all outputs and running state in one cycle.
  - Takes priority over a simultaneous beat; that beat is dropped.
- bin_reset is asynchronous. Assertion mid-frame discards the frame with no stats_valid.

## Timing
- Reset value of every output: 0 (peak_bin, peak_count, total_count, occupied_bins, stats_valid, frame_error, frame_cnt).
- Latency: outputs and stats_valid change on the clock edge that samples the last beat. They are visible the following cycle.
- stats_valid is high for exactly one cycle per good frame.
- Result outputs are stable from that edge until the next good frame's final edge, a clear, or a reset.
- Back-to-back frames (last beat, then bin 0 on the next cycle) are supported. The IDLE-state start logic consumes that beat with no lost cycle.
- No backpressure; the block accepts one beat every cycle.
- All-zero frame: peak_bin=0, peak_count=0, total=0, occupied=0, stats_valid=1.

## Structure
- Shared package hist_pkg:
  - Constants NUM_BINS, IDX_W, DATA_W, TOTAL_W (shared with the histogrammer).
  - State enum {IDLE, ACCUM, DRAIN}.
- One sub-module: hist_peak_cmp.
  - Combinational compare/select of (run_peak, run_bin) against (data_in, idx).
  - Strict greater-than; outputs the next peak and index.
- The top holds the FSM, counters and output registers.

## Test plan
- Bins 0..63 = index value (0..63) with last on beat 63 → peak_bin=63, peak_count=63, total=2016, occupied=63, stats_valid one cycle, frame_cnt=1.
- Bin 5 = 255, bin 40 = 255, all others 1 → peak_bin=5 (tie keeps lowest), peak_count=255, total=572, occupied=64.
- Valid frame with 3 idle gaps inserted → same results as the gap-free frame; stats_valid one cycle after the last beat.
- last_in on beat 20 → frame_error=1, no stats_valid, previous results held. The next good frame clears frame_error.
- 70 beats with last on beat 70 → frame_error=1 at beat 64, DRAIN until last, back to IDLE. The next good frame publishes correctly.
- Mid-frame clear, and separately mid-frame bin_reset → all outputs 0, no stats_valid. 256 good frames → frame_cnt wraps to 0.
